// File: rtl/perf_counter_pkg.sv
// perf_counter_pkg: shared types and helpers for the performance counter bank
package perf_counter_pkg;
  localparam int MAX_W = 64;
  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;
  typedef struct packed {
    logic [MAX_W-1:0] count;
    logic             ovf;
  } counter_state_t;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one live counter with clear > load > increment priority and wrap/saturate overflow
module perf_counter_cell
  import perf_counter_pkg::*;
#(
  parameter int        WIDTH = 64,
  parameter int        INC_W = 4,
  parameter cnt_mode_e MODE  = CNT_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [INC_W-1:0] inc,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] count,
  output logic             ovf
);
  logic [WIDTH:0] sum;
  assign sum = {1'b0, count} + {{(WIDTH + 1 - INC_W){1'b0}}, inc};
  always_ff @(posedge clk) begin
    count <= (rst || clr) ? '0 : ld ? ld_data : (sum[WIDTH] && MODE == CNT_SAT) ? '1 : sum[WIDTH-1:0];
    ovf   <= !(rst || clr) && (ovf || (!ld && sum[WIDTH]));
  end
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: NUM_CH event counters with atomic shadow snapshot and 1-cycle read port
module perf_counter_bank
  import perf_counter_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 64,
  parameter int INC_W    = 4,
  parameter int SATURATE = 0,
  localparam int IW      = idx_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH*INC_W-1:0] inc_amt,
  input  logic [NUM_CH-1:0]       clear,
  input  logic                    ld_valid,
  input  logic [IW-1:0]           ld_ch,
  input  logic [WIDTH-1:0]        ld_data,
  input  logic                    snap,
  input  logic                    rd_req,
  input  logic [IW-1:0]           rd_sel,
  output logic                    rd_valid,
  output logic [WIDTH-1:0]        rd_data,
  output logic                    rd_ovf,
  output logic [NUM_CH-1:0]       ovf
);
  localparam int DEPTH = 1 << IW;
  logic [WIDTH-1:0] cnt [DEPTH];
  logic [DEPTH-1:0] ovf_all;
  counter_state_t   shadow [DEPTH];
  // Lanes past NUM_CH are tied to zero so out-of-range reads return 0 without a range check
  for (genvar c = 0; c < DEPTH; c++) begin : g_ch
    if (c < NUM_CH) begin : g_cell
      perf_counter_cell #(
        .WIDTH(WIDTH),
        .INC_W(INC_W),
        .MODE (SATURATE != 0 ? CNT_SAT : CNT_WRAP)
      ) u_cell (
        .clk    (clk),
        .rst    (rst),
        .clr    (clear[c]),
        .ld     (ld_valid && ld_ch == IW'(c)),
        .inc    (inc_amt[c*INC_W +: INC_W]),
        .ld_data(ld_data),
        .count  (cnt[c]),
        .ovf    (ovf_all[c])
      );
    end else begin : g_pad
      assign cnt[c]     = '0;
      assign ovf_all[c] = 1'b0;
    end
  end
  assign ovf = ovf_all[NUM_CH-1:0];
  always_ff @(posedge clk) begin
    for (int c = 0; c < DEPTH; c++)
      if (rst) shadow[c] <= '0;
      else if (snap) shadow[c] <= '{count: MAX_W'(cnt[c]), ovf: ovf_all[c]};
    rd_valid <= !rst && rd_req;
    if (rst) begin
      rd_data <= '0;
      rd_ovf  <= 1'b0;
    end else if (rd_req) begin
      rd_data <= shadow[rd_sel].count[WIDTH-1:0];
      rd_ovf  <= shadow[rd_sel].ovf;
    end
  end
endmodule

// File: tb/tb_perf_counter_bank.sv
// tb_perf_counter_bank: randomized + directed check of a 64-bit wrap bank and an 8-bit saturating bank
module tb_perf_counter_bank;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        rst = 1'b1;
  logic [15:0] inc_amt;
  logic [3:0]  clear;
  logic        ld_valid;
  logic [1:0]  ld_ch;
  logic [63:0] ld_data;
  logic        snap;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic        rv_a, ro_a, rv_b, ro_b;
  logic [63:0] rd_a;
  logic [7:0]  rd_b;
  logic [3:0]  ovf_a, ovf_b;
  perf_counter_bank #(.NUM_CH(4), .WIDTH(64), .INC_W(4), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .inc_amt(inc_amt), .clear(clear), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_data(ld_data), .snap(snap), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv_a), .rd_data(rd_a), .rd_ovf(ro_a), .ovf(ovf_a));
  perf_counter_bank #(.NUM_CH(4), .WIDTH(8), .INC_W(4), .SATURATE(1)) dut_b (
    .clk(clk), .rst(rst), .inc_amt(inc_amt), .clear(clear), .ld_valid(ld_valid),
    .ld_ch(ld_ch), .ld_data(ld_data[7:0]), .snap(snap), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_valid(rv_b), .rd_data(rd_b), .rd_ovf(ro_b), .ovf(ovf_b));

  int errors = 0;
  int checks = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  longint unsigned la[4], sa[4], e_rda;
  int              lb[4], sb[4], e_rdb;
  bit              loa[4], soa[4], lob[4], sob[4], e_roa, e_rob, e_rv;
  bit              started = 0;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        la[c] = 0; sa[c] = 0; lb[c] = 0; sb[c] = 0;
        loa[c] = 0; soa[c] = 0; lob[c] = 0; sob[c] = 0;
      end
      e_rv = 0; e_rda = 0; e_roa = 0; e_rdb = 0; e_rob = 0;
      started = 1;
    end else begin
      e_rv = rd_req;
      if (rd_req) begin
        e_rda = sa[rd_sel]; e_roa = soa[rd_sel];
        e_rdb = sb[rd_sel]; e_rob = sob[rd_sel];
      end
      if (snap)
        for (int c = 0; c < 4; c++) begin
          sa[c] = la[c]; soa[c] = loa[c]; sb[c] = lb[c]; sob[c] = lob[c];
        end
      for (int c = 0; c < 4; c++) begin
        longint unsigned nxt;
        int inc, s;
        inc = int'(inc_amt[c*4 +: 4]);
        if (clear[c]) begin
          la[c] = 0; loa[c] = 0; lb[c] = 0; lob[c] = 0;
        end else if (ld_valid && int'(ld_ch) == c) begin
          la[c] = ld_data; lb[c] = int'(ld_data[7:0]);
        end else begin
          nxt = la[c] + longint'(inc);
          if (nxt < la[c]) loa[c] = 1;
          la[c] = nxt;
          s = lb[c] + inc;
          if (s > 255) begin lb[c] = 255; lob[c] = 1; end
          else lb[c] = s;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0] oa, ob;
      for (int c = 0; c < 4; c++) begin oa[c] = loa[c]; ob[c] = lob[c]; end
      chk("rd_valid_a", {63'd0, rv_a}, {63'd0, e_rv});
      chk("rd_data_a", rd_a, e_rda);
      chk("rd_ovf_a", {63'd0, ro_a}, {63'd0, e_roa});
      chk("ovf_a", {60'd0, ovf_a}, {60'd0, oa});
      chk("rd_valid_b", {63'd0, rv_b}, {63'd0, e_rv});
      chk("rd_data_b", {56'd0, rd_b}, 64'(e_rdb));
      chk("rd_ovf_b", {63'd0, ro_b}, {63'd0, e_rob});
      chk("ovf_b", {60'd0, ovf_b}, {60'd0, ob});
    end
  end

  task automatic step();
    @(negedge clk);
  endtask
  task automatic idle();
    inc_amt = '0; clear = '0; ld_valid = 0; ld_ch = '0; ld_data = '0;
    snap = 0; rd_req = 0; rd_sel = '0;
  endtask
  task automatic rd(input int sel);
    rd_req = 1; rd_sel = 2'(sel); step(); rd_req = 0;
  endtask
  task automatic ld(input int ch, input logic [63:0] d);
    ld_valid = 1; ld_ch = 2'(ch); ld_data = d; step(); ld_valid = 0;
  endtask
  task automatic do_snap();
    snap = 1; step(); snap = 0;
  endtask

  initial begin
    idle();
    rst = 1; step(); step(); rst = 0;
    chk("rst_rd_valid", {63'd0, rv_a}, 64'd0);
    chk("rst_rd_data", rd_a, 64'd0);
    chk("rst_ovf", {60'd0, ovf_a}, 64'd0);
    inc_amt[3:0] = 4'd1; repeat (10) step(); inc_amt = '0;
    do_snap();
    rd(0);
    chk("t1_rd_valid", {63'd0, rv_a}, 64'd1);
    chk("t1_rd_data", rd_a, 64'd10);
    chk("t1_rd_ovf", {63'd0, ro_a}, 64'd0);
    chk("t1_rd_data_b", {56'd0, rd_b}, 64'd10);
    for (int c = 1; c < 4; c++) begin
      rd(c);
      chk("t1_other", rd_a, 64'd0);
    end
    ld(1, 64'h0000_0000_FFFF_FFFE);
    inc_amt[7:4] = 4'd3; step(); inc_amt = '0;
    do_snap(); rd(1);
    chk("t2_carry", rd_a, 64'h0000_0001_0000_0001);
    chk("t2_ovf", {63'd0, ovf_a[1]}, 64'd0);
    chk("t2_sat_b", {56'd0, rd_b}, 64'hFF);
    chk("t2_ovf_b", {63'd0, ro_b}, 64'd1);
    ld(2, 64'hFFFF_FFFF_FFFF_FFFF);
    inc_amt[11:8] = 4'd2; step(); inc_amt = '0;
    chk("t3_ovf_set", {63'd0, ovf_a[2]}, 64'd1);
    do_snap(); rd(2);
    chk("t3_wrap", rd_a, 64'd1);
    chk("t3_rd_ovf", {63'd0, ro_a}, 64'd1);
    clear[2] = 1; step(); clear = '0;
    chk("t3_ovf_clr", {63'd0, ovf_a[2]}, 64'd0);
    do_snap(); rd(2);
    chk("t3_cleared", rd_a, 64'd0);
    ld(0, 64'hFD);
    inc_amt[3:0] = 4'd5; step(); inc_amt = '0;
    do_snap(); rd(0);
    chk("t4_sat", {56'd0, rd_b}, 64'hFF);
    chk("t4_sat_ovf", {63'd0, ro_b}, 64'd1);
    chk("t4_wide", rd_a, 64'h102);
    inc_amt[3:0] = 4'd1; step(); inc_amt = '0;
    do_snap(); rd(0);
    chk("t4_sat_hold", {56'd0, rd_b}, 64'hFF);
    ld(3, 64'd7);
    clear[3] = 1; ld_valid = 1; ld_ch = 2'd3; ld_data = 64'd50; inc_amt[15:12] = 4'd4; snap = 1;
    step(); idle();
    rd(3);
    chk("t5_snap_pre", rd_a, 64'd7);
    do_snap(); rd(3);
    chk("t5_clear_wins", rd_a, 64'd0);
    ld(0, 64'd5); do_snap(); ld(0, 64'd9);
    snap = 1; rd_req = 1; rd_sel = 2'd0; step(); idle();
    chk("t6_old_shadow", rd_a, 64'd5);
    rd(0);
    chk("t6_new_shadow", rd_a, 64'd9);
    rd_req = 1; rst = 1; step(); rst = 0; rd_req = 0;
    chk("t6_rst_cancel", {63'd0, rv_a}, 64'd0);
    repeat (3000) begin
      rst = ($urandom_range(0, 299) == 0);
      inc_amt = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      for (int c = 0; c < 4; c++) clear[c] = ($urandom_range(0, 15) == 0);
      ld_valid = ($urandom_range(0, 7) == 0);
      ld_ch = 2'($urandom);
      case ($urandom_range(0, 2))
        0: ld_data = {$urandom, $urandom};
        1: ld_data = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 20));
        default: ld_data = 64'($urandom_range(0, 300));
      endcase
      snap = ($urandom_range(0, 3) == 0);
      rd_req = ($urandom_range(0, 1) == 0);
      rd_sel = 2'($urandom);
      step();
    end
    rst = 0; idle(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
